rc4_xor_stream: RTL

RC4_XOR_STREAM -- requirements
Module: rc4_xor_stream

---
 rtl/rc4_xor_stream_if.sv | 23 ++
 rtl/rc4_xor_stream.sv | 117 +++++++++++
 2 files changed

// File: rtl/rc4_xor_stream_if.sv
// Byte-stream bundle for the RC4 XOR stage: keystream in, data in, result out.
// The environment side is the master; the XOR block is the slave.
interface rc4_xor_stream_if;
    logic       ks_valid;
    logic [7:0] ks_data;
    logic       ks_ready;
    logic       din_valid;
    logic [7:0] din;
    logic       din_ready;
    logic       dout_valid;
    logic [7:0] dout;
    logic       dout_ready;

    modport master (
        output ks_valid, ks_data, din_valid, din, dout_ready,
        input  ks_ready, din_ready, dout_valid, dout
    );

    modport slave (
        input  ks_valid, ks_data, din_valid, din, dout_ready,
        output ks_ready, din_ready, dout_valid, dout
    );
endinterface

// File: rtl/rc4_xor_stream.sv
// XORs a message byte stream with RC4 keystream bytes buffered in a small FIFO,
// producing one result byte per input byte through a single output register.
module rc4_xor_stream #(
    parameter int KS_DEPTH = 4,
    parameter int LEN_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
    rc4_xor_stream_if.slave  bus,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] byte_cnt
);
    localparam int AW = (KS_DEPTH > 1) ? $clog2(KS_DEPTH) : 1;
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t           state_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_d;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    fill;
    logic [7:0]       fifo_mem [KS_DEPTH];
    logic [7:0]       head;
    logic [7:0]       dout_q;
    logic             dout_valid_q;
    logic             fifo_full;
    logic             fifo_empty;
    logic             ks_push;
    logic             din_pop;
    logic             dout_fire;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign fill       = wr_ptr_q - rd_ptr_q;
    assign fifo_full  = (fill == PW'(KS_DEPTH));
    assign fifo_empty = (fill == '0);
    assign head       = fifo_mem[rd_ptr_q[AW-1:0]];

    assign bus.ks_ready  = (state_q == RUN) && !fifo_full;
    assign bus.din_ready = (state_q == RUN) && !fifo_empty && (cnt_q < len_q)
                           && (!dout_valid_q || bus.dout_ready);
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;

    assign ks_push   = bus.ks_valid && bus.ks_ready;
    assign din_pop   = bus.din_valid && bus.din_ready;
    assign dout_fire = dout_valid_q && bus.dout_ready;
    assign cnt_d     = din_pop ? (cnt_q + LEN_W'(1)) : cnt_q;

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign byte_cnt = cnt_q;

    always_ff @(posedge clk) begin
        if (ks_push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= bus.ks_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            dout_q       <= 8'h00;
            dout_valid_q <= 1'b0;
        end else begin
            if (ks_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (din_pop) begin
                rd_ptr_q     <= rd_ptr_q + PW'(1);
                dout_q       <= bus.din ^ head;
                dout_valid_q <= 1'b1;
            end else if (dout_fire) begin
                dout_valid_q <= 1'b0;
            end
            cnt_q <= cnt_d;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        len_q    <= msg_len;
                        cnt_q    <= '0;
                        wr_ptr_q <= '0;
                        rd_ptr_q <= '0;
                        state_q  <= (msg_len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    // Leave as soon as the final byte is taken so done tracks its drain.
                    if (cnt_d == len_q) begin
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (!dout_valid_q || dout_fire) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
